// File: rtl/noc_packet_arbiter_pkg.sv
// Shared types and defaults for the NoC packet arbiter and its round-robin picker.
// The requester count and the idle-lock timeout default live here.
package noc_packet_arbiter_pkg;

  localparam int NOC_VC_CHANNEL          = 4;
  localparam int NOC_ARB_TIMEOUT_DEFAULT = 256;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  // Index width that never collapses to zero bits for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [idx_width(NOC_VC_CHANNEL)-1:0] noc_owner_id_t;

endpackage

// File: rtl/noc_rr_picker.sv
// Combinational round-robin picker: the first set request at or after ptr, wrapping modulo N.
// It is shared with the VC and switch allocators.
module noc_rr_picker
  import noc_packet_arbiter_pkg::*;
#(
  parameter  int N  = NOC_VC_CHANNEL,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] index,
  output logic          any
);

  always_comb begin
    int j;
    j      = 0;
    winner = '0;
    index  = '0;
    any    = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && request[j]) begin
        winner[j] = 1'b1;
        index     = IW'(j);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_packet_arbiter.sv
// Wormhole packet arbiter: holds one grant from head to tail flit, then rotates round-robin.
// Define NOC_ARB_TIMEOUT_EN to force-release a lock whose owner stalls for TimeoutCycles cycles.
module noc_packet_arbiter
  import noc_packet_arbiter_pkg::*;
#(
  parameter  int Channel       = NOC_VC_CHANNEL,
  parameter  int TimeoutCycles = NOC_ARB_TIMEOUT_DEFAULT,
  localparam int IW            = idx_width(Channel)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [Channel-1:0] request,
  input  logic [Channel-1:0] free,
  input  logic [Channel-1:0] start_of_packet,
  input  logic [Channel-1:0] end_of_packet,
  output logic [Channel-1:0] grant,
  output logic               owner_valid,
  output logic [IW-1:0]      owner_id,
  output logic               proto_err
);

  if (Channel < 1 || TimeoutCycles < 2) begin : g_bad_params
    $error("noc_packet_arbiter: needs Channel >= 1 and TimeoutCycles >= 2");
  end

  arb_state_t         state_q, state_d;
  logic [Channel-1:0] grant_d;
  logic [IW-1:0]      owner_d;
  logic [IW-1:0]      ptr_q, ptr_d, ptr_after, pick_ptr;
  logic [Channel-1:0] win_oh;
  logic [IW-1:0]      win_idx;
  logic               win_any;
  logic               head_q, head_d;
  logic               perr_d;
  logic               locked, xfer, owner_free, owner_sop, owner_eop;
  logic               timeout_hit, release_ev;

  assign locked      = (state_q == ARB_LOCKED);
  assign owner_valid = locked;
  assign owner_free  = free[owner_id];
  assign owner_sop   = start_of_packet[owner_id];
  assign owner_eop   = end_of_packet[owner_id];
  // grant[owner_id] is implied whenever locked, so the transfer reduces to the owner's request.
  assign xfer        = locked & request[owner_id];
  assign release_ev  = locked & (owner_free | (xfer & owner_eop) | timeout_hit);

  // With a single requester this always evaluates to 0.
  assign ptr_after = (owner_id == IW'(Channel - 1)) ? '0 : owner_id + 1'b1;
  assign pick_ptr  = release_ev ? ptr_after : ptr_q;

  noc_rr_picker #(.N(Channel)) u_picker (
    .request (request),
    .ptr     (pick_ptr),
    .winner  (win_oh),
    .index   (win_idx),
    .any     (win_any)
  );

`ifdef NOC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TimeoutCycles) + 1;
  logic [CW-1:0] idle_cnt_q;

  assign timeout_hit = locked & ~xfer & (idle_cnt_q == CW'(TimeoutCycles - 1));

  always_ff @(posedge clk) begin
    if (rst || !locked || xfer || release_ev) idle_cnt_q <= '0;
    else                                      idle_cnt_q <= idle_cnt_q + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant;
    owner_d = owner_id;
    ptr_d   = ptr_q;
    head_d  = head_q;
    perr_d  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (win_any) begin
          state_d = ARB_LOCKED;
          grant_d = win_oh;
          owner_d = win_idx;
          head_d  = 1'b1;
        end
      end
      ARB_LOCKED: begin
        // An abort wins over a simultaneous flit, so that flit is not head-checked.
        if (xfer && !owner_free) begin
          head_d = 1'b0;
          if (head_q != owner_sop) perr_d = 1'b1;
        end
        if (timeout_hit) perr_d = 1'b1;
        if (release_ev) begin
          ptr_d = ptr_after;
          if (win_any) begin
            grant_d = win_oh;
            owner_d = win_idx;
            head_d  = 1'b1;
          end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      grant     <= '0;
      owner_id  <= '0;
      ptr_q     <= '0;
      head_q    <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant     <= grant_d;
      owner_id  <= owner_d;
      ptr_q     <= ptr_d;
      head_q    <= head_d;
      proto_err <= perr_d;
    end
  end

endmodule

// File: tb/tb_noc_packet_arbiter.sv
// Scoreboard bench for noc_packet_arbiter with Channel=4: directed scenarios plus random traffic
// checked against a packet-level reference model.
module tb_noc_packet_arbiter;

  localparam int CH = 4;
`ifdef NOC_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 256;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] request, free, sop, eop;
  logic [CH-1:0] grant;
  logic          owner_valid;
  logic [1:0]    owner_id;
  logic          proto_err;

  noc_packet_arbiter #(.Channel(CH), .TimeoutCycles(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .request         (request),
    .free            (free),
    .start_of_packet (sop),
    .end_of_packet   (eop),
    .grant           (grant),
    .owner_valid     (owner_valid),
    .owner_id        (owner_id),
    .proto_err       (proto_err)
  );

  always #5 clk = ~clk;

  // Expected {grant, owner_valid, owner_id, proto_err} for the cycle after each applied vector.
  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model state: owner lane (-1 when nobody holds the lock), rotation start,
  // last reported owner index, whether a head flit is still due, and consecutive stall cycles.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_id    = 0;
  int m_stall = 0;
  bit m_head  = 1'b0;

  function automatic int rr_pick(input logic [CH-1:0] rq, input int from);
    for (int i = 0; i < CH; i++)
      if (rq[(from + i) % CH]) return (from + i) % CH;
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [CH-1:0] rq, input logic [CH-1:0] s,
                            input logic [CH-1:0] e, input logic [CH-1:0] f);
    bit            perr = 1'b0;
    bit            rel  = 1'b0;
    int            w;
    logic [CH-1:0] g;
    if (r) begin
      m_owner = -1; m_ptr = 0; m_id = 0; m_stall = 0; m_head = 1'b0;
    end else if (m_owner < 0) begin
      w = rr_pick(rq, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_id = w; m_head = 1'b1; m_stall = 0;
      end
    end else begin
      if (f[m_owner]) rel = 1'b1;
      else if (rq[m_owner]) begin
        if (s[m_owner] != m_head) perr = 1'b1;
        m_head  = 1'b0;
        m_stall = 0;
        if (e[m_owner]) rel = 1'b1;
      end else begin
        m_stall++;
`ifdef NOC_ARB_TIMEOUT_EN
        if (m_stall == TO) begin
          rel  = 1'b1;
          perr = 1'b1;
        end
`endif
      end
      if (rel) begin
        m_ptr   = (m_owner + 1) % CH;
        m_stall = 0;
        w = rr_pick(rq, m_ptr);
        if (w >= 0) begin
          m_owner = w; m_id = w; m_head = 1'b1;
        end else begin
          m_owner = -1;
        end
      end
    end
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    exp_q.push_back({g, (m_owner >= 0), 2'(m_id), perr});
  endtask

  task automatic step(input logic r, input logic [CH-1:0] rq, input logic [CH-1:0] s,
                      input logic [CH-1:0] e, input logic [CH-1:0] f);
    @(negedge clk);
    rst     = r;
    request = rq;
    sop     = s;
    eop     = e;
    free    = f;
    model_step(r, rq, s, e, f);
  endtask

  // Monitor: every rising edge produces a new output word; compare it with the oldest expectation.
  initial begin
    logic [7:0] exp_w, act_w;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        act_w = {grant, owner_valid, owner_id, proto_err};
        n_vec++;
        if (act_w !== exp_w) begin
          n_err++;
          $display("FAIL arb_out t=%0t got grant=%b valid=%b id=%0d perr=%b, expected grant=%b valid=%b id=%0d perr=%b",
                   $time, act_w[7:4], act_w[3], act_w[2:1], act_w[0],
                   exp_w[7:4], exp_w[3], exp_w[2:1], exp_w[0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; request = '0; free = '0; sop = '0; eop = '0;
    step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Lane 1 wins, sends three flits; back-to-back handoff to lane 2, then lane 0, then lane 1.
    step(0, 4'b0110, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b0110, 4'b0010, 4'b0000, 4'b0000);
    step(0, 4'b0110, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b0111, 4'b0000, 4'b0010, 4'b0000);
    step(0, 4'b0111, 4'b0100, 4'b0000, 4'b0000);
    step(0, 4'b0111, 4'b0000, 4'b0100, 4'b0000);
    step(0, 4'b0111, 4'b0001, 4'b0001, 4'b0000);
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Lane 2: free coinciding with a tail flit is one release; non-owner free is ignored.
    step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
    step(0, 4'b0100, 4'b0000, 4'b0100, 4'b0100);
    step(0, 4'b0101, 4'b0100, 4'b0000, 4'b0001);
    step(0, 4'b0101, 4'b0000, 4'b0100, 4'b0000);
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Lane 3 single-flit packets, bubble, then abort to idle.
    step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b1000, 4'b1000, 4'b1000, 4'b0000);
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b1000, 4'b1000, 4'b1000, 4'b0000);
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Missing head flit, a stray head later, then reset in the middle of the packet.
    step(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    step(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    step(1, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Long owner stall while other lanes keep requesting.
    step(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
    repeat (300) step(0, 4'b1011, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b0100, 4'b0000, 4'b0100, 4'b0000);
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b1111);

    // Random traffic; the owner usually marks its head flit correctly.
    for (int k = 0; k < 3000; k++) begin
      logic [CH-1:0] rq, s, e, f;
      logic          r;
      rq = CH'($urandom);
      s  = CH'($urandom);
      e  = CH'($urandom) & CH'($urandom);
      f  = ($urandom_range(0, 15) == 0) ? CH'($urandom) : '0;
      if (m_owner >= 0 && $urandom_range(0, 9) != 0) s[m_owner] = m_head;
      r  = ($urandom_range(0, 199) == 0);
      step(r, rq, s, e, f);
    end

    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/noc_packet_arbiter.md
Name: noc_packet_arbiter

Overview:
- Packet-level (wormhole) arbiter on the controller side of the NoC VC control bundle.
- Shares one output resource among Channel requesters and grants exactly one at a time.
- Locks the grant from packet start to packet end, then rotates priority round-robin.
- Instantiated once per router output port, in front of the crossbar/output-buffer stage.

Parameters:
- Channel, default Noc_VC_Channel (from Noc_parameters): number of requesters / VC lanes.
- TimeoutCycles, default 256: idle cycles tolerated while locked (used only with the optional feature).

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- request  input  Channel  per-requester: wants the resource / has a flit valid this cycle
- free  input  Channel  per-requester: abort; releases an owned lock immediately
- start_of_packet  input  Channel  qualifies the current flit as a head flit
- end_of_packet  input  Channel  qualifies the current flit as a tail flit
- grant  output  Channel  registered one-hot (or zero) grant
- owner_valid  output  1  lock held
- owner_id  output  max(1,$clog2(Channel))  index of current owner
- proto_err  output  1  one-cycle pulse on protocol violation

Behaviour:
- Reset: grant=0, owner_valid=0, owner_id=0, proto_err=0, rr pointer=0, FSM=IDLE, timeout counter=0.
- Transfer on lane i = request[i] & grant[i]. start_of_packet, end_of_packet and free are sampled only for the owner lane; other lanes are ignored.
- Round-robin: search starts at pointer, wraps modulo Channel. After any release, pointer = owner_id+1 (wrapping Channel-1 to 0).
- FSM IDLE: if any request is set, the winner is registered. Next cycle: grant[w]=1, owner_valid=1, owner_id=w, go to LOCKED. Request-to-grant latency is 1 cycle. With no request, stay IDLE with grant=0.
- FSM LOCKED: grant is held while the owner's request is low (bubbles allowed); no other lane can preempt.
- Release from LOCKED occurs on:
  - an owner transfer with end_of_packet=1, or
  - free[owner]=1 (takes priority over a simultaneous transfer).
- On release, arbitration runs in the same cycle using the updated pointer; the owner is eligible only at lowest priority. Next cycle: either the new grant (back-to-back, no bubble) or IDLE with grant=0.
- Single-flit packet (start_of_packet & end_of_packet on one transfer): lock and release in that same cycle.
- Head check:
  - The first owner transfer after a grant must carry start_of_packet; otherwise proto_err pulses next cycle and the lock is kept.
  - start_of_packet on a later owner transfer also pulses proto_err.
- Channel=1: the pointer is constant 0, and the lock/release rules are unchanged.
- rst asserted mid-packet: all state returns to reset values in the next cycle, and the lock is dropped without an end_of_packet.

Optional Feature:
- Macro NOC_ARB_TIMEOUT_EN.
- Defined:
  - A counter increments each LOCKED cycle without an owner transfer and clears on any owner transfer or on release.
  - When it reaches TimeoutCycles-1, the lock is force-released exactly as for free, and proto_err pulses.
- Undefined: no counter logic; a lock persists indefinitely until end_of_packet, free or rst.

Decomposition:
- Noc_parameters gains:
  - the arbiter state enum {ARB_IDLE, ARB_LOCKED}
  - the owner-index typedef sized from Noc_VC_Channel
  - the default timeout constant.
- Natural sub-module: noc_rr_picker, a combinational round-robin one-hot picker with inputs request vector and pointer, and output one-hot winner plus index. It is reused by the VC and switch allocators.
- Top-level ports connect to the controller modport of Noc_control_interface.

Test Plan (all with Channel=4):
- Reset, then request=4'b0110 → one cycle later grant=4'b0010, owner_id=1; grant is still 4'b0010 while lane 1 sends 3 flits (start_of_packet on the first, end_of_packet on the third).
- Lane 1 releases with request=4'b0111 held → grant=4'b0100 on the very next cycle, no bubble; after that packet ends, grant goes to lane 0.
- Lane 2 locked, free[2]=1 in the same cycle as an end_of_packet transfer → single release; pointer=3; free[0]=1 on a non-owner lane has no effect.
- Single-flit packet on lane 3 (start_of_packet & end_of_packet) with request=4'b1000 → grant 1 cycle, then it re-grants lane 3 only if it is still requesting.
- Owner's first transfer lacks start_of_packet → proto_err is high for exactly 1 cycle and the grant is kept. rst asserted mid-packet → grant=0 and owner_valid=0 next cycle.
- With NOC_ARB_TIMEOUT_EN and TimeoutCycles=8: owner stalls 8 cycles → forced release plus a proto_err pulse. Without the macro, a 300-cycle stall keeps the grant.
